// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage.
// State encoding and reset vector.
package pc_pkg;

  typedef enum logic [1:0] {
    EXECUTANDO = 2'd0,
    ESPERANDO  = 2'd1,
    PARADO     = 2'd2
  } estado_t;

  localparam int PC_RESET = 0;

endpackage

// File: rtl/unidade_pc_contador_saturado.sv
// Saturating retired-instruction counter.
// Holds at all-ones instead of wrapping.
module contador_saturado #(
  parameter int CONT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  incrementa,
  output logic [CONT_WIDTH-1:0] valor
);

  logic [CONT_WIDTH-1:0] valor_q, valor_d;

  // next count: +1 unless already saturated
  always_comb begin
    valor_d = valor_q;
    if (incrementa && (valor_q != '1))
      valor_d = valor_q + CONT_WIDTH'(1);
  end

  // count register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) valor_q <= '0;
    else       valor_q <= valor_d;
  end

  assign valor = valor_q;

endmodule

// File: rtl/unidade_pc.sv
// Program-counter stage: PC register, next-PC
// selection, input-wait/halt FSM, retire counter.
module unidade_pc
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int CONT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jump,
  input  logic                  jump_al,
  input  logic                  jalr,
  input  logic                  branch_tomado,
  input  logic [ADDR_WIDTH-1:0] endereco_imediato,
  input  logic [DATA_WIDTH-1:0] endereco_registrador,
  input  logic                  halt,
  input  logic                  espera_entrada,
  input  logic                  entrada_valida,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] proximo_pc,
  output logic                  esperando,
  output logic                  parado,
  output logic [CONT_WIDTH-1:0] instrucoes_executadas
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  estado_t               estado_q, estado_d;
  logic                  incrementa;
  logic                  unused_reg_hi;

  // JALR targets beyond the instruction space are truncated
  assign unused_reg_hi =
    ^endereco_registrador[DATA_WIDTH-1:ADDR_WIDTH];

  assign proximo_pc = pc_q + ADDR_WIDTH'(1);

  // next-state, next-PC and retire decision
  always_comb begin
    pc_d       = pc_q;
    estado_d   = estado_q;
    incrementa = 1'b0;
    unique case (estado_q)
      EXECUTANDO: begin
        if (halt) begin
          estado_d   = PARADO;
          incrementa = 1'b1;
        end else if (espera_entrada && !entrada_valida) begin
          estado_d = ESPERANDO;
        end else begin
          incrementa = 1'b1;
          if (jalr)
            pc_d = endereco_registrador[ADDR_WIDTH-1:0];
          else if (jump || jump_al)
            pc_d = endereco_imediato;
          else if (branch_tomado)
            pc_d = endereco_imediato;
          else
            pc_d = proximo_pc;
        end
      end
      ESPERANDO: begin
        if (entrada_valida) begin
          pc_d       = proximo_pc;
          incrementa = 1'b1;
          estado_d   = EXECUTANDO;
        end
      end
      PARADO: begin
      end
      default: estado_d = EXECUTANDO;
    endcase
  end

  // PC and state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= ADDR_WIDTH'(PC_RESET);
      estado_q <= EXECUTANDO;
    end else begin
      pc_q     <= pc_d;
      estado_q <= estado_d;
    end
  end

  contador_saturado #(
    .CONT_WIDTH(CONT_WIDTH)
  ) u_contador (
    .clock     (clock),
    .reset     (reset),
    .incrementa(incrementa),
    .valor     (instrucoes_executadas)
  );

  assign pc        = pc_q;
  assign esperando = (estado_q == ESPERANDO);
  assign parado    = (estado_q == PARADO);

endmodule

// File: tb/tb_unidade_pc.sv
// Self-checking bench for unidade_pc: directed table,
// randomized run against a reference model, saturation.
module tb_unidade_pc;

  logic        clock = 1'b0;
  logic        reset, jump, jump_al, jalr, branch_tomado;
  logic        halt, espera_entrada, entrada_valida;
  logic [12:0] endereco_imediato;
  logic [31:0] endereco_registrador;
  logic [12:0] pc, proximo_pc, pc_s, proximo_pc_s;
  logic        esperando, parado, esperando_s, parado_s;
  logic [31:0] instrucoes_executadas;
  logic [2:0]  cont_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  unidade_pc dut (
    .clock(clock), .reset(reset),
    .jump(jump), .jump_al(jump_al), .jalr(jalr),
    .branch_tomado(branch_tomado),
    .endereco_imediato(endereco_imediato),
    .endereco_registrador(endereco_registrador),
    .halt(halt), .espera_entrada(espera_entrada),
    .entrada_valida(entrada_valida),
    .pc(pc), .proximo_pc(proximo_pc),
    .esperando(esperando), .parado(parado),
    .instrucoes_executadas(instrucoes_executadas)
  );

  unidade_pc #(.CONT_WIDTH(3)) dut_sat (
    .clock(clock), .reset(reset),
    .jump(jump), .jump_al(jump_al), .jalr(jalr),
    .branch_tomado(branch_tomado),
    .endereco_imediato(endereco_imediato),
    .endereco_registrador(endereco_registrador),
    .halt(halt), .espera_entrada(espera_entrada),
    .entrada_valida(entrada_valida),
    .pc(pc_s), .proximo_pc(proximo_pc_s),
    .esperando(esperando_s), .parado(parado_s),
    .instrucoes_executadas(cont_s)
  );

  typedef struct {
    logic        rst, hlt, esp, val, jr, jmp, jal, br;
    logic [12:0] imm;
    logic [31:0] rgv;
    int          e_pc, e_cnt;
    logic        e_esp, e_par;
  } vec_t;

  // reference model: abstract machine state
  int     m_pc;
  bit     m_wait, m_halt;
  longint m_cnt;
  int     m_cnt3;

  function automatic void retire();
    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (m_cnt3 < 7) m_cnt3++;
  endfunction

  function automatic void model_step(vec_t v);
    if (v.rst) begin
      m_pc = 0; m_wait = 0; m_halt = 0;
      m_cnt = 0; m_cnt3 = 0;
    end else if (m_halt) begin
    end else if (m_wait) begin
      if (v.val) begin
        m_pc = (m_pc + 1) % 8192;
        m_wait = 0;
        retire();
      end
    end else if (v.hlt) begin
      m_halt = 1;
      retire();
    end else if (v.esp && !v.val) begin
      m_wait = 1;
    end else begin
      if (v.jr) m_pc = int'(v.rgv % 8192);
      else if (v.jmp || v.jal || v.br) m_pc = int'(v.imm);
      else m_pc = (m_pc + 1) % 8192;
      retire();
    end
  endfunction

  task automatic check(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(vec_t v);
    reset = v.rst; halt = v.hlt;
    espera_entrada = v.esp; entrada_valida = v.val;
    jalr = v.jr; jump = v.jmp; jump_al = v.jal;
    branch_tomado = v.br;
    endereco_imediato = v.imm;
    endereco_registrador = v.rgv;
    @(posedge clock);
    #1;
    model_step(v);
  endtask

  task automatic check_model(string tag);
    check({tag, " pc"}, longint'(pc), longint'(m_pc));
    check({tag, " proximo_pc"}, longint'(proximo_pc),
          longint'((m_pc + 1) % 8192));
    check({tag, " esperando"}, longint'(esperando),
          longint'(m_wait));
    check({tag, " parado"}, longint'(parado), longint'(m_halt));
    check({tag, " contador"},
          longint'(instrucoes_executadas), m_cnt);
    check({tag, " contador3"}, longint'(cont_s),
          longint'(m_cnt3));
  endtask

  function automatic vec_t mk(logic rst, logic hlt, logic esp,
      logic val, logic jr, logic jmp, logic jal, logic br,
      int imm, logic [31:0] rgv,
      int e_pc, logic e_esp, logic e_par, int e_cnt);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.esp = esp; v.val = val;
    v.jr = jr; v.jmp = jmp; v.jal = jal; v.br = br;
    v.imm = 13'(imm); v.rgv = rgv;
    v.e_pc = e_pc; v.e_esp = e_esp; v.e_par = e_par;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tab[$];
  vec_t rv;

  initial begin
    // rst hlt esp val jr jmp jal br imm rgv | pc esp par cnt
    tab.push_back(mk(1,0,0,0,0,0,0,0,0,0,     0,0,0,0));
    for (int i = 1; i <= 4; i++)
      tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,   i,0,0,i));
    tab.push_back(mk(0,0,0,0,0,1,0,0,10,0,    10,0,0,5));
    tab.push_back(mk(0,0,0,0,1,1,0,0,100,32'hFFFF_E005,
                                              5,0,0,6));
    tab.push_back(mk(0,0,0,0,0,0,1,0,13'h1FFF,0,
                                              13'h1FFF,0,0,7));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,     0,0,0,8));
    tab.push_back(mk(0,0,0,0,0,0,0,1,20,0,    20,0,0,9));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0,0,1,0,0,0,0,0,0,0,   20,1,0,9));
    tab.push_back(mk(0,0,0,1,0,0,0,0,0,0,     21,0,0,10));
    tab.push_back(mk(0,0,0,0,0,1,0,0,20,0,    20,0,0,11));
    tab.push_back(mk(0,0,1,1,0,0,0,0,0,0,     21,0,0,12));
    tab.push_back(mk(0,0,0,0,0,1,0,0,30,0,    30,0,0,13));
    tab.push_back(mk(0,1,0,0,0,0,0,0,0,0,     30,0,1,14));
    for (int i = 0; i < 10; i++)
      tab.push_back(mk(0,0,0,i%2==0,0,i%2==0,0,i%2==1,
                       500,0,                 30,0,1,14));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0,0,     0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,     1,0,0,1));
    tab.push_back(mk(0,0,1,0,0,0,0,0,0,0,     1,1,0,1));
    tab.push_back(mk(1,0,0,1,0,0,0,0,0,0,     0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,     1,0,0,1));

    m_pc = 0; m_wait = 0; m_halt = 0; m_cnt = 0; m_cnt3 = 0;

    foreach (tab[i]) begin
      step(tab[i]);
      check($sformatf("tab%0d pc", i), longint'(pc),
            longint'(tab[i].e_pc));
      check($sformatf("tab%0d proximo_pc", i),
            longint'(proximo_pc),
            longint'((tab[i].e_pc + 1) % 8192));
      check($sformatf("tab%0d esperando", i),
            longint'(esperando), longint'(tab[i].e_esp));
      check($sformatf("tab%0d parado", i),
            longint'(parado), longint'(tab[i].e_par));
      check($sformatf("tab%0d contador", i),
            longint'(instrucoes_executadas),
            longint'(tab[i].e_cnt));
    end

    // saturation on the narrow-counter instance
    step(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    for (int i = 1; i <= 10; i++) begin
      step(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
      check($sformatf("sat%0d", i), longint'(cont_s),
            longint'(i < 7 ? i : 7));
    end
    check("sat pc", longint'(pc_s), 64'd10);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rv = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
      rv.rst = ($urandom_range(0, 99) == 0);
      rv.hlt = ($urandom_range(0, 59) == 0);
      rv.esp = ($urandom_range(0, 7) == 0);
      rv.val = ($urandom_range(0, 3) == 0);
      rv.jr  = ($urandom_range(0, 9) == 0);
      rv.jmp = ($urandom_range(0, 9) == 0);
      rv.jal = ($urandom_range(0, 9) == 0);
      rv.br  = ($urandom_range(0, 7) == 0);
      rv.imm = 13'($urandom);
      rv.rgv = $urandom;
      step(rv);
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_pc.md
Name: unidade_pc

Overview:
Program-counter stage of the processor. It holds the PC register and selects the next PC from sequential, branch, jump/JAL and JALR sources. It stalls on input-wait instructions and stops on HALT. It drives `pc` to instruction memory and `proximo_pc` (PC+1) to the JAL/JALR write-back mux, where PC+1 is saved as the return address.

Parameters:
- DATA_WIDTH, 32, width of register-file data (JALR target source).
- ADDR_WIDTH, 13, width of instruction address / PC.
- CONT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- jump  input  1  unconditional jump (J).
- jump_al  input  1  jump-and-link (JAL); same target as jump.
- jalr  input  1  jump-and-link-register.
- branch_tomado  input  1  branch condition true AND branch instruction.
- endereco_imediato  input  ADDR_WIDTH  absolute target for jump/jump_al/branch.
- endereco_registrador  input  DATA_WIDTH  JALR target from register file.
- halt  input  1  HALT instruction decoded.
- espera_entrada  input  1  IN instruction decoded; must wait for user input.
- entrada_valida  input  1  one-cycle pulse: user input available.
- pc  output  ADDR_WIDTH  current PC (registered).
- proximo_pc  output  ADDR_WIDTH  pc+1, combinational from pc.
- esperando  output  1  high in state ESPERANDO.
- parado  output  1  high in state PARADO.
- instrucoes_executadas  output  CONT_WIDTH  retired-instruction count.

Behaviour:
- Reset (synchronous, highest priority): pc=0, state=EXECUTANDO, instrucoes_executadas=0, esperando=0, parado=0. Reset asserted in any state, including mid-wait, returns to these values on that edge.
- proximo_pc = pc + 1, modulo 2^ADDR_WIDTH. pc = all-ones gives proximo_pc = 0.
- States: EXECUTANDO, ESPERANDO, PARADO. esperando and parado are decoded directly from the state register.
- EXECUTANDO, per edge, first matching rule wins:
  1. halt: pc holds; go to PARADO; counter +1 (HALT retires).
  2. espera_entrada & !entrada_valida: pc holds; go to ESPERANDO; counter unchanged.
  3. jalr: pc <= endereco_registrador[ADDR_WIDTH-1:0]. Upper DATA_WIDTH-ADDR_WIDTH bits are ignored.
  4. jump | jump_al: pc <= endereco_imediato.
  5. branch_tomado: pc <= endereco_imediato.
  6. otherwise (including espera_entrada & entrada_valida in the same cycle): pc <= proximo_pc.
  - Cases 3–6 increment the counter by 1.
- ESPERANDO: pc holds; control inputs are ignored except entrada_valida and reset.
  - On entrada_valida: pc <= proximo_pc, counter +1, return to EXECUTANDO.
- PARADO: sticky. pc and counter hold regardless of all inputs; only reset exits.
- Multiple control inputs high at once (decoder fault) are resolved by the priority above; no error flag.
- Counter saturates at 2^CONT_WIDTH-1; it never wraps.
- Latency: new pc is visible one cycle after the deciding edge. No combinational path from control inputs to pc; proximo_pc depends only on pc.

Decomposition:
- Shared package (`pc_pkg`):
  - state encoding constants EXECUTANDO=2'd0, ESPERANDO=2'd1, PARADO=2'd2;
  - reset vector constant PC_RESET=0.
- One natural sub-module: `contador_saturado` (parameterised CONT_WIDTH, inputs clock/reset/incrementa, output valor).
- Next-PC selection and FSM stay in `unidade_pc`.

Test Plan:
- Reset then 5 idle cycles -> pc 0,1,2,3,4; proximo_pc = pc+1; instrucoes_executadas=4 after the 4th advance edge; esperando=parado=0.
- pc=10, jalr=1, endereco_registrador=32'hFFFF_E005 -> next pc=13'h0005 (upper bits dropped); same cycle jump=1, endereco_imediato=100 -> jalr wins, pc=5.
- pc=13'h1FFF, no control -> pc=0, proximo_pc=1 (wrap).
- pc=20, espera_entrada=1 for 3 cycles without entrada_valida -> pc stays 20, esperando=1, counter frozen; entrada_valida pulse -> pc=21, esperando=0, counter +1. Separately, espera_entrada & entrada_valida in the same cycle -> pc=21 directly, esperando never set.
- pc=30, halt=1 -> parado=1, pc=30 held for 10 cycles while jump/branch toggle; reset -> pc=0, parado=0, counter 0.
- Reset asserted while in ESPERANDO with entrada_valida also high -> reset wins: pc=0, state EXECUTANDO; counter preset to 2^32-2, two advances -> stays 32'hFFFF_FFFF.
